// File: rtl/forth_irq_ctrl.sv
// forth_irq_ctrl -- interrupt controller for the Forth CPU core.
// Latches rising edges on the peripheral lines, masks them, and presents the
// lowest-index enabled request with its handler vector. One handler at a time:
// IDLE -> REQ (interrupt held) -> SERVICE (busy) -> IDLE on reti.
// Optional build macro: IRQ_SYNC_EN adds a 2-flop input synchronizer in front
// of edge detection (request latency grows by 2 cycles). Default: irq_in is
// assumed synchronous to clk.
module forth_irq_ctrl #(
    parameter int               WIDTH       = 16,
    parameter int               NUM_IRQ     = 4,
    parameter logic [WIDTH-1:0] VECTOR_BASE = WIDTH'('h0010),
    parameter int               VECTOR_STEP = 2
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_data,
    input  logic               wfi,
    input  logic               ack,
    input  logic               reti,
    output logic               interrupt,
    output logic [WIDTH-1:0]   vector,
    output logic               busy,
    output logic [NUM_IRQ-1:0] pending,
    output logic               wake
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [NUM_IRQ-1:0] irq_seen;
    logic [NUM_IRQ-1:0] irq_prev_reg;
    logic [NUM_IRQ-1:0] pending_reg;
    logic [NUM_IRQ-1:0] pending_next;
    logic [NUM_IRQ-1:0] mask_reg;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] clear_vec;
    logic [IDX_W-1:0]   idx_reg;
    logic [IDX_W-1:0]   win_idx;
    logic [WIDTH-1:0]   vector_reg;
    logic [WIDTH-1:0]   vector_calc;
    logic               wake_reg;
    logic               take_req;
    logic               ack_take;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_reg;
    logic [NUM_IRQ-1:0] sync2_reg;

    // Two-stage synchronizer for asynchronous peripheral lines
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= irq_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign irq_seen = sync2_reg;
`else
    assign irq_seen = irq_in;
`endif

    assign active = pending_reg & mask_reg;

    // Priority encoder: scanning downwards leaves the lowest active index
    always_comb begin
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    assign vector_calc = VECTOR_BASE + WIDTH'(win_idx) * WIDTH'(VECTOR_STEP);

    // Next-state logic; take_req latches idx/vector, ack_take retires the request
    always_comb begin
        state_next = state_reg;
        take_req   = 1'b0;
        ack_take   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|active) begin
                    take_req   = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    ack_take   = 1'b1;
                    state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (reti) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Per-line clear strobe for the acknowledged request
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_clear
            assign clear_vec[gi] = ack_take && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    // A new edge in the ack cycle overrides the clear so it is not lost
    assign pending_next = (pending_reg & ~clear_vec) | (irq_seen & ~irq_prev_reg);

    // FSM state register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Edge detect, pending latch, mask, request capture and wake-up
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            irq_prev_reg <= '0;
            pending_reg  <= '0;
            mask_reg     <= '0;
            idx_reg      <= '0;
            vector_reg   <= '0;
            wake_reg     <= 1'b0;
        end else begin
            irq_prev_reg <= irq_seen;
            pending_reg  <= pending_next;
            wake_reg     <= wfi && (|active);
            if (mask_we) begin
                mask_reg <= mask_data;
            end
            if (take_req) begin
                idx_reg    <= win_idx;
                vector_reg <= vector_calc;
            end
        end
    end

    assign interrupt = (state_reg == ST_REQ);
    assign busy      = (state_reg == ST_SERVICE);
    assign vector    = vector_reg;
    assign pending   = pending_reg;
    assign wake      = wake_reg;

endmodule

// File: tb/tb_forth_irq_ctrl.sv
// Testbench for forth_irq_ctrl: directed scenarios followed by a randomized
// run checked cycle-by-cycle against a behavioural model.
module tb_forth_irq_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic        clk = 1'b0;
    logic        nreset;
    logic [3:0]  irq_in;
    logic        mask_we;
    logic [3:0]  mask_data;
    logic        wfi;
    logic        ack;
    logic        reti;
    logic        interrupt;
    logic [15:0] vector;
    logic        busy;
    logic [3:0]  pending;
    logic        wake;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    logic [3:0]  m_prev, m_pend, m_mask, m_s1, m_s2;
    int          m_phase;  // 0 waiting, 1 requesting, 2 handler running
    int          m_idx;
    logic [15:0] m_vec;
    logic        m_wake;

    always #5 clk = ~clk;

    forth_irq_ctrl dut (
        .clk       (clk),
        .nreset    (nreset),
        .irq_in    (irq_in),
        .mask_we   (mask_we),
        .mask_data (mask_data),
        .wfi       (wfi),
        .ack       (ack),
        .reti      (reti),
        .interrupt (interrupt),
        .vector    (vector),
        .busy      (busy),
        .pending   (pending),
        .wake      (wake)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        nreset = 1'b0; irq_in = '0; mask_we = 0; mask_data = '0;
        wfi = 0; ack = 0; reti = 0;
        step(2);
        nreset = 1'b1;
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_we = 1'b1; mask_data = m;
        step(1);
        mask_we = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] lines);
        irq_in = lines;
        step(1);
        irq_in = '0;
        step(SYNC);
    endtask

    task automatic ack_reti();
        ack = 1; step(1); ack = 0;
        reti = 1; step(1); reti = 0;
    endtask

    task automatic test_reset();
        nreset = 1'b0; irq_in = 4'b1000; mask_we = 0; mask_data = '0;
        wfi = 0; ack = 0; reti = 0;
        step(2);
        n_cmp++; if ({interrupt, busy, wake} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {interrupt, busy, wake}); end
        n_cmp++; if (vector !== 16'h0000) begin n_err++; $display("FAIL reset_vector: got %h expected 0000", vector); end
        n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL reset_pending: got %b expected 0000", pending); end
        nreset = 1'b1;
        step(1 + SYNC);
        n_cmp++; if (pending !== 4'b1000) begin n_err++; $display("FAIL reset_high_line_edge: got %b expected 1000", pending); end
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL reset_mask_zero: got %b expected 0", interrupt); end
        $display("tb: test_reset done");
        do_reset();
    endtask

    task automatic test_single();
        write_mask(4'b1111);
        pulse(4'b0100);
        n_cmp++; if (pending !== 4'b0100) begin n_err++; $display("FAIL single_pending: got %b expected 0100", pending); end
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL single_early_irq: got %b expected 0", interrupt); end
        step(1);
        n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL single_irq: got %b expected 1", interrupt); end
        n_cmp++; if (vector !== 16'h0014) begin n_err++; $display("FAIL single_vector: got %h expected 0014", vector); end
        ack = 1; step(1); ack = 0;
        n_cmp++; if ({interrupt, busy} !== 2'b01) begin n_err++; $display("FAIL single_ack: got %b expected 01", {interrupt, busy}); end
        n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL single_ack_pending: got %b expected 0000", pending); end
        reti = 1; step(1); reti = 0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_reti: got %b expected 0", busy); end
        step(1);
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b expected 0", interrupt); end
        $display("tb: test_single done");
    endtask

    task automatic test_priority();
        pulse(4'b1010);
        step(1);
        n_cmp++; if (vector !== 16'h0012 || interrupt !== 1'b1) begin n_err++; $display("FAIL prio_first: got irq=%b vec=%h expected irq=1 vec=0012", interrupt, vector); end
        ack = 1; step(1); ack = 0;
        n_cmp++; if (pending !== 4'b1000) begin n_err++; $display("FAIL prio_pending: got %b expected 1000", pending); end
        reti = 1; step(1); reti = 0;
        n_cmp++; if ({interrupt, busy} !== 2'b00) begin n_err++; $display("FAIL prio_gap: got %b expected 00", {interrupt, busy}); end
        step(1);
        n_cmp++; if (vector !== 16'h0016 || interrupt !== 1'b1) begin n_err++; $display("FAIL prio_second: got irq=%b vec=%h expected irq=1 vec=0016", interrupt, vector); end
        ack_reti();
        $display("tb: test_priority done");
    endtask

    task automatic test_masked();
        write_mask(4'b0000);
        pulse(4'b0001);
        step(2);
        n_cmp++; if (interrupt !== 1'b0 || pending !== 4'b0001) begin n_err++; $display("FAIL masked_hold: got irq=%b pend=%b expected irq=0 pend=0001", interrupt, pending); end
        write_mask(4'b0001);
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL masked_write_edge: got %b expected 0", interrupt); end
        step(1);
        n_cmp++; if (interrupt !== 1'b1 || vector !== 16'h0010) begin n_err++; $display("FAIL masked_unmask: got irq=%b vec=%h expected irq=1 vec=0010", interrupt, vector); end
        ack_reti();
        write_mask(4'b1111);
        $display("tb: test_masked done");
    endtask

    task automatic test_wake();
        wfi = 1;
        pulse(4'b0010);
        n_cmp++; if (pending !== 4'b0010 || wake !== 1'b0) begin n_err++; $display("FAIL wake_early: got pend=%b wake=%b expected pend=0010 wake=0", pending, wake); end
        step(1);
        n_cmp++; if (wake !== 1'b1) begin n_err++; $display("FAIL wake_rise: got %b expected 1", wake); end
        wfi = 0;
        step(1);
        n_cmp++; if (wake !== 1'b0) begin n_err++; $display("FAIL wake_fall: got %b expected 0", wake); end
        ack_reti();
        $display("tb: test_wake done");
    endtask

    task automatic test_freeze_and_async_reset();
        pulse(4'b0100);
        step(1);
        mask_we = 1; mask_data = 4'b0000; irq_in = 4'b0001;
        step(1);
        mask_we = 0;
        n_cmp++; if (interrupt !== 1'b1 || vector !== 16'h0014) begin n_err++; $display("FAIL freeze_1: got irq=%b vec=%h expected irq=1 vec=0014", interrupt, vector); end
        step(1);
        n_cmp++; if (interrupt !== 1'b1 || vector !== 16'h0014) begin n_err++; $display("FAIL freeze_2: got irq=%b vec=%h expected irq=1 vec=0014", interrupt, vector); end
        irq_in = 4'b0101;
        step(SYNC);
        ack = 1; step(1); ack = 0;
        n_cmp++; if ({interrupt, busy} !== 2'b01) begin n_err++; $display("FAIL freeze_ack: got %b expected 01", {interrupt, busy}); end
        n_cmp++; if (pending !== 4'b0101) begin n_err++; $display("FAIL ack_edge_wins: got %b expected 0101", pending); end
        // asynchronous reset in mid-cycle while a handler runs
        #2 nreset = 1'b0;
        #1;
        n_cmp++; if ({interrupt, busy} !== 2'b00 || pending !== 4'b0000 || vector !== 16'h0000) begin n_err++; $display("FAIL async_reset: got irq=%b busy=%b pend=%b vec=%h expected all 0", interrupt, busy, pending, vector); end
        irq_in = '0;
        step(1);
        nreset = 1'b1;
        pulse(4'b0010);
        step(2);
        n_cmp++; if (pending !== 4'b0010 || interrupt !== 1'b0) begin n_err++; $display("FAIL async_mask_cleared: got pend=%b irq=%b expected pend=0010 irq=0", pending, interrupt); end
        $display("tb: test_freeze_and_async_reset done");
        do_reset();
    endtask

    // Behavioural model: advance one clock using the current inputs
    task automatic model_edge();
        logic [3:0] seen, act, np;
        int w;
        seen = (SYNC > 0) ? m_s2 : irq_in;
        act  = m_pend & m_mask;
        np   = m_pend;
        if (m_phase == 1 && ack) np[m_idx] = 1'b0;
        np = np | (seen & ~m_prev);
        m_wake = wfi && (act != 4'b0000);
        if (m_phase == 0) begin
            if (act != 4'b0000) begin
                w = 0;
                while (!act[w]) w++;
                m_idx   = w;
                m_vec   = 16'(16'h0010 + w * 2);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (ack) m_phase = 2;
        end else begin
            if (reti) m_phase = 0;
        end
        m_prev = seen;
        m_s2   = m_s1;
        m_s1   = irq_in;
        m_pend = np;
        if (mask_we) m_mask = mask_data;
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = n_err;
        m_prev = '0; m_pend = '0; m_mask = '0; m_s1 = '0; m_s2 = '0;
        m_phase = 0; m_idx = 0; m_vec = '0; m_wake = 0;
        for (int c = 0; c < 400; c++) begin
            irq_in    = 4'($urandom);
            mask_we   = ($urandom_range(0, 5) == 0);
            mask_data = 4'($urandom);
            wfi       = 1'($urandom);
            ack       = ($urandom_range(0, 2) == 0);
            reti      = ($urandom_range(0, 2) == 0);
            model_edge();
            step(1);
            n_cmp++; if (interrupt !== (m_phase == 1)) begin n_err++; $display("FAIL rnd_interrupt c=%0d: got %b expected %b", c, interrupt, (m_phase == 1)); end
            n_cmp++; if (busy !== (m_phase == 2)) begin n_err++; $display("FAIL rnd_busy c=%0d: got %b expected %b", c, busy, (m_phase == 2)); end
            n_cmp++; if (vector !== m_vec) begin n_err++; $display("FAIL rnd_vector c=%0d: got %h expected %h", c, vector, m_vec); end
            n_cmp++; if (pending !== m_pend) begin n_err++; $display("FAIL rnd_pending c=%0d: got %b expected %b", c, pending, m_pend); end
            n_cmp++; if (wake !== m_wake) begin n_err++; $display("FAIL rnd_wake c=%0d: got %b expected %b", c, wake, m_wake); end
        end
        irq_in = '0; mask_we = 0; wfi = 0; ack = 0; reti = 0;
        $display("tb: test_random done, %0d new errors", n_err - errs_before);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_masked();
        test_wake();
        test_freeze_and_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
